// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared single-ported main memory: sequences
// I/D block fills and D-side single-word writes with alternating priority.
module mem_arbiter #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned BLOCK_WORDS = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_req,
   input  logic [ADDR_W-1:0]              i_addr,
   input  logic                           d_req,
   input  logic                           d_we,
   input  logic [ADDR_W-1:0]              d_addr,
   input  logic [15:0]                    d_wdata,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [15:0]                    mem_wdata,
   input  logic [15:0]                    mem_rdata,
   input  logic                           mem_valid,
   output logic [15:0]                    fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
   output logic                           i_fill_we,
   output logic                           d_fill_we,
   output logic                           i_done,
   output logic                           d_done
);

   localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
   localparam logic [ADDR_W-1:0] FILL_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);
   localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(1);
   localparam logic [OFF_W:0]    IC_END    = (OFF_W + 1)'(BLOCK_WORDS);
   localparam logic [OFF_W-1:0]  RC_LAST   = OFF_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

   state_t            state;
   logic              last_d;
   logic [OFF_W:0]    ic;
   logic [OFF_W-1:0]  rc;
   logic [ADDR_W-1:0] base;

   logic grant_d_c;
   logic grant_i_c;
   logic last_word_c;

   // On a collision the side that did not win last time is granted.
   assign grant_d_c   = d_req & (~i_req | ~last_d);
   assign grant_i_c   = i_req & ~grant_d_c;
   assign last_word_c = (rc == RC_LAST);

   // Fill-side strobes must coincide with mem_valid, so they are decoded here.
   assign fill_data = mem_rdata;
   assign fill_word = rc;
   assign i_fill_we = (state == I_FILL) & mem_valid;
   assign d_fill_we = (state == D_FILL) & mem_valid;
   assign i_done    = i_fill_we & last_word_c;
   assign d_done    = (d_fill_we & last_word_c) | (state == D_WRITE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_d    <= 1'b0;
         ic        <= '0;
         rc        <= '0;
         base      <= '0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d_c) begin
                  last_d <= 1'b1;
                  mem_en <= 1'b1;
                  if (d_we) begin
                     state     <= D_WRITE;
                     mem_wr    <= 1'b1;
                     mem_addr  <= d_addr & ~WORD_MASK;
                     mem_wdata <= d_wdata;
                  end else begin
                     state    <= D_FILL;
                     base     <= d_addr & ~FILL_MASK;
                     mem_addr <= d_addr & ~FILL_MASK;
                     ic       <= (OFF_W + 1)'(1);
                  end
               end else if (grant_i_c) begin
                  last_d   <= 1'b0;
                  state    <= I_FILL;
                  mem_en   <= 1'b1;
                  base     <= i_addr & ~FILL_MASK;
                  mem_addr <= i_addr & ~FILL_MASK;
                  ic       <= (OFF_W + 1)'(1);
               end
            end
            I_FILL, D_FILL: begin
               // Word offset is OR-ed into the aligned base, so it wraps in-block.
               if (ic < IC_END) begin
                  mem_en   <= 1'b1;
                  mem_addr <= base | ADDR_W'({ic[OFF_W-1:0], 1'b0});
                  ic       <= ic + (OFF_W + 1)'(1);
               end else begin
                  mem_en   <= 1'b0;
                  mem_addr <= '0;
               end
               if (mem_valid) begin
                  if (last_word_c) begin
                     state    <= IDLE;
                     rc       <= '0;
                     ic       <= '0;
                     mem_en   <= 1'b0;
                     mem_addr <= '0;
                  end else begin
                     rc <= rc + OFF_W'(1);
                  end
               end
            end
            D_WRITE: begin
               state     <= IDLE;
               mem_en    <= 1'b0;
               mem_wr    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
